// File: rtl/trace_event_pkg.sv
// Shared types and constants for the trace event capture stage.
package trace_event_pkg;

    localparam int unsigned TIME_W = 64;

    localparam logic [7:0]  NOP_OPCODE  = 8'h15;
    localparam logic [15:0] K_EXIT      = 16'h0001;
    localparam logic [15:0] K_PUTC      = 16'h0004;
    localparam logic [15:0] K_USER_BASE = 16'h0020;

    typedef enum logic [1:0] {
        EV_EXIT = 2'd0,
        EV_PUTC = 2'd1,
        EV_USER = 2'd2
    } ev_type_t;

    // One captured event; stamp is wide enough for any counter up to TIME_W bits.
    typedef struct packed {
        ev_type_t          kind;
        logic [3:0]        code;
        logic [31:0]       pc;
        logic [31:0]       r3;
        logic              supv;
        logic [TIME_W-1:0] stamp;
        logic              lost;
    } trace_event_t;

endpackage

// File: rtl/trace_event_fifo.sv
// Synchronous FIFO of trace_event_t; head is read straight from register storage.
module trace_event_fifo
    import trace_event_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  trace_event_t wdata,
    output trace_event_t head,
    output logic         empty,
    output logic         full
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    trace_event_t mem [DEPTH];

    // Storage and pointers; storage clears so the head reads zero after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= wdata;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/trace_event_capture.sv
// Decodes l.nop simulation-control events at write-back, timestamps and queues them.
module trace_event_capture
    import trace_event_pkg::*;
#(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_sys_n,
    input  logic                 enable,
    input  logic [31:0]          wb_pc,
    input  logic [31:0]          wb_insn,
    input  logic [31:0]          r3,
    input  logic                 supv,
    output logic                 ev_valid,
    input  logic                 ev_ready,
    output logic [1:0]           ev_type,
    output logic [3:0]           ev_code,
    output logic [31:0]          ev_pc,
    output logic [31:0]          ev_r3,
    output logic                 ev_supv,
    output logic [CNT_WIDTH-1:0] ev_time,
    output logic                 ev_lost,
    output logic                 halted,
    output logic [7:0]           drop_cnt
);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [CNT_WIDTH-1:0]   retire_cnt;
    logic                   lost_flag;

    logic                   is_exit_c;
    logic                   is_putc_c;
    logic                   is_user_c;
    logic                   event_c;
    logic                   push_c;
    logic                   pop_c;
    logic                   drop_c;
    logic                   fifo_empty;
    logic                   fifo_full;
    logic                   unused_c;
    trace_event_t           rec_c;
    trace_event_t           head;

    // Event decode and record assembly for the retiring instruction.
    always_comb begin
        is_exit_c = 1'b0;
        is_putc_c = 1'b0;
        is_user_c = 1'b0;
        rec_c     = '0;
        if (wb_insn[31:24] == NOP_OPCODE) begin
            is_exit_c = (wb_insn[15:0] == K_EXIT);
            is_putc_c = (wb_insn[15:0] == K_PUTC);
            is_user_c = (wb_insn[15:4] == K_USER_BASE[15:4]);
        end
        event_c    = enable && (state == ST_RUN) && (is_exit_c || is_putc_c || is_user_c);
        rec_c.kind = is_exit_c ? EV_EXIT : (is_putc_c ? EV_PUTC : EV_USER);
        rec_c.code = is_user_c ? wb_insn[3:0] : 4'd0;
        rec_c.pc    = wb_pc;
        rec_c.r3    = r3;
        rec_c.supv  = supv;
        rec_c.stamp = TIME_W'(retire_cnt);
        rec_c.lost  = lost_flag;
    end

    // A full FIFO still accepts a push when its head leaves in the same cycle.
    assign pop_c  = ev_valid && ev_ready;
    assign push_c = event_c && (!fifo_full || pop_c);
    assign drop_c = event_c && !push_c;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Only a successfully queued exit halts capture; HALTED is left by reset alone.
    always_comb begin
        state_nxt = state;
        if ((state == ST_RUN) && push_c && is_exit_c) begin
            state_nxt = ST_HALTED;
        end
    end

    // Retire counter, frozen once halted.
    always_ff @(posedge clk or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            retire_cnt <= '0;
        end else if (enable && (state == ST_RUN)) begin
            retire_cnt <= retire_cnt + CNT_WIDTH'(1);
        end
    end

    // Drop accounting: saturating counter plus sticky flag carried by the next record.
    always_ff @(posedge clk or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            drop_cnt  <= '0;
            lost_flag <= 1'b0;
        end else if (drop_c) begin
            lost_flag <= 1'b1;
            if (drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end else if (push_c) begin
            lost_flag <= 1'b0;
        end
    end

    trace_event_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_sys_n),
        .push  (push_c),
        .pop   (pop_c),
        .wdata (rec_c),
        .head  (head),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign ev_valid = !fifo_empty;
    assign ev_type  = head.kind;
    assign ev_code  = head.code;
    assign ev_pc    = head.pc;
    assign ev_r3    = head.r3;
    assign ev_supv  = head.supv;
    assign ev_time  = CNT_WIDTH'(head.stamp);
    assign ev_lost  = head.lost;
    assign halted   = (state == ST_HALTED);

    // Register-index fields of the nop and stamp bits beyond the counter carry no event data.
    assign unused_c = ^{wb_insn[23:16], head.stamp};

endmodule

// File: tb/tb_trace_event_capture.sv
// Scoreboard bench for trace_event_capture: stimulus queues expected records, a monitor checks pops.
module tb_trace_event_capture;
    import trace_event_pkg::*;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned CW    = 32;

    localparam logic [31:0] I_PUTC = 32'h15000004;
    localparam logic [31:0] I_EXIT = 32'h15000001;
    localparam logic [31:0] I_ADD  = 32'hE0632000;

    logic          clk = 1'b0;
    logic          rst_sys_n;
    logic          enable;
    logic [31:0]   wb_pc;
    logic [31:0]   wb_insn;
    logic [31:0]   r3;
    logic          supv;
    logic          ev_valid;
    logic          ev_ready;
    logic [1:0]    ev_type;
    logic [3:0]    ev_code;
    logic [31:0]   ev_pc;
    logic [31:0]   ev_r3;
    logic          ev_supv;
    logic [CW-1:0] ev_time;
    logic          ev_lost;
    logic          halted;
    logic [7:0]    drop_cnt;

    trace_event_t  sb[$];
    int            n_cmp = 0;
    int            n_err = 0;
    logic [CW-1:0] tcount;
    bit            halted_m;

    trace_event_capture #(.DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
        .clk       (clk),
        .rst_sys_n (rst_sys_n),
        .enable    (enable),
        .wb_pc     (wb_pc),
        .wb_insn   (wb_insn),
        .r3        (r3),
        .supv      (supv),
        .ev_valid  (ev_valid),
        .ev_ready  (ev_ready),
        .ev_type   (ev_type),
        .ev_code   (ev_code),
        .ev_pc     (ev_pc),
        .ev_r3     (ev_r3),
        .ev_supv   (ev_supv),
        .ev_time   (ev_time),
        .ev_lost   (ev_lost),
        .halted    (halted),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: a pop happens at the next posedge when valid and ready are both high now.
    always @(negedge clk) begin : mon
        trace_event_t act;
        trace_event_t exp;
        if (rst_sys_n === 1'b1 && ev_valid === 1'b1 && ev_ready === 1'b1) begin
            act.kind  = ev_type_t'(ev_type);
            act.code  = ev_code;
            act.pc    = ev_pc;
            act.r3    = ev_r3;
            act.supv  = ev_supv;
            act.stamp = 64'(ev_time);
            act.lost  = ev_lost;
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_record: got pc=0x%0h r3=0x%0h expected no record", ev_pc, ev_r3);
            end else begin
                exp = sb.pop_front();
                if (act !== exp) begin
                    n_err++;
                    $display("FAIL record: got type=%0d code=%0h pc=%0h r3=%0h supv=%0d time=%0d lost=%0d expected type=%0d code=%0h pc=%0h r3=%0h supv=%0d time=%0d lost=%0d",
                             act.kind, act.code, act.pc, act.r3, act.supv, act.stamp, act.lost,
                             exp.kind, exp.code, exp.pc, exp.r3, exp.supv, exp.stamp, exp.lost);
                end
            end
        end
    end

    // One retire cycle; when exp_push is set the hand-described record is queued.
    task automatic retire(input logic [31:0] insn, input logic [31:0] pc, input logic [31:0] rv,
                          input logic sv, input bit exp_push, input ev_type_t kind,
                          input logic [3:0] code, input bit lost);
        trace_event_t e;
        enable  = 1'b1;
        wb_insn = insn;
        wb_pc   = pc;
        r3      = rv;
        supv    = sv;
        if (exp_push) begin
            e.kind  = kind;
            e.code  = code;
            e.pc    = pc;
            e.r3    = rv;
            e.supv  = sv;
            e.stamp = 64'(tcount);
            e.lost  = lost;
            sb.push_back(e);
        end
        if (!halted_m) tcount++;
        @(posedge clk);
        #1;
        enable = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int max);
        int k = 0;
        while ((sb.size() != 0 || ev_valid) && k < max) begin
            @(posedge clk);
            #1;
            k++;
        end
        n_cmp++;
        if (sb.size() != 0 || ev_valid) begin
            n_err++;
            $display("FAIL %s: got %0d records pending expected 0 within %0d cycles", name, sb.size(), max);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic model_reset();
        sb.delete();
        tcount   = '0;
        halted_m = 1'b0;
    endtask

    initial begin
        rst_sys_n = 1'b0;
        enable    = 1'b0;
        ev_ready  = 1'b0;
        wb_insn   = '0;
        wb_pc     = '0;
        r3        = '0;
        supv      = 1'b0;
        model_reset();
        idle(2);

        check("rst_valid", 64'(ev_valid), 64'd0);
        check("rst_halted", 64'(halted), 64'd0);
        check("rst_drop", 64'(drop_cnt), 64'd0);
        check("rst_pc", 64'(ev_pc), 64'd0);
        check("rst_time", 64'(ev_time), 64'd0);
        rst_sys_n = 1'b1;
        idle(1);

        // putc after five plain retirements: time 5, visible one cycle later
        ev_ready = 1'b1;
        for (int i = 0; i < 5; i++) retire(I_ADD, 32'h1000 + 32'(4*i), 32'h0, 1'b0, 1'b0, EV_PUTC, 4'd0, 1'b0);
        check("t1_valid_before", 64'(ev_valid), 64'd0);
        retire(I_PUTC, 32'h2000, 32'h41, 1'b0, 1'b1, EV_PUTC, 4'd0, 1'b0);
        check("t1_valid_after", 64'(ev_valid), 64'd1);
        check("t1_time_head", 64'(ev_time), 64'd5);
        wait_drain("t1_drain", 10);

        // user event in supervisor mode; neighbouring non-events produce nothing
        retire(32'h15000025, 32'h2100, 32'h77, 1'b1, 1'b1, EV_USER, 4'd5, 1'b0);
        retire(32'h15000040, 32'h2104, 32'h0, 1'b0, 1'b0, EV_PUTC, 4'd0, 1'b0);
        retire(I_ADD,        32'h2108, 32'h0, 1'b0, 1'b0, EV_PUTC, 4'd0, 1'b0);
        retire(32'h15000030, 32'h210C, 32'h0, 1'b0, 1'b0, EV_PUTC, 4'd0, 1'b0);
        retire(32'h14000001, 32'h2110, 32'h0, 1'b0, 1'b0, EV_PUTC, 4'd0, 1'b0);
        retire(32'h1500002F, 32'h2114, 32'h9, 1'b0, 1'b1, EV_USER, 4'hF, 1'b0);
        wait_drain("t2_drain", 10);

        // full FIFO with ready held: 20 back-to-back events, no drops
        ev_ready = 1'b0;
        for (int i = 0; i < 8; i++) retire(I_PUTC, 32'h3000 + 32'(4*i), 32'h100 + 32'(i), 1'b0, 1'b1, EV_PUTC, 4'd0, 1'b0);
        check("t4_full_valid", 64'(ev_valid), 64'd1);
        ev_ready = 1'b1;
        for (int i = 0; i < 20; i++) retire(I_PUTC, 32'h3100 + 32'(4*i), 32'h200 + 32'(i), 1'b0, 1'b1, EV_PUTC, 4'd0, 1'b0);
        check("t4_drop", 64'(drop_cnt), 64'd0);
        wait_drain("t4_drain", 40);

        // overflow: 8 queued, 3 dropped, then exit carries lost and halts
        ev_ready = 1'b0;
        for (int i = 0; i < 8; i++) retire(I_PUTC, 32'h4000 + 32'(4*i), 32'h300 + 32'(i), 1'b0, 1'b1, EV_PUTC, 4'd0, 1'b0);
        for (int i = 0; i < 3; i++) retire(I_PUTC, 32'h4100 + 32'(4*i), 32'h3F0, 1'b0, 1'b0, EV_PUTC, 4'd0, 1'b0);
        check("t3_drop", 64'(drop_cnt), 64'd3);
        check("t3_head_stable", 64'(ev_r3), 64'h300);
        ev_ready = 1'b1;
        wait_drain("t3_drain", 20);
        check("t3_halted_before", 64'(halted), 64'd0);
        retire(I_EXIT, 32'h4200, 32'h0, 1'b0, 1'b1, EV_EXIT, 4'd0, 1'b1);
        halted_m = 1'b1;
        check("t3_halted", 64'(halted), 64'd1);
        for (int i = 0; i < 3; i++) retire(I_PUTC, 32'h4300 + 32'(4*i), 32'h55, 1'b0, 1'b0, EV_PUTC, 4'd0, 1'b0);
        wait_drain("t3_drain_halted", 20);
        check("t3_drop_after", 64'(drop_cnt), 64'd3);
        check("t3_still_halted", 64'(halted), 64'd1);

        // asynchronous reset mid-cycle clears halted and drop count
        @(posedge clk);
        #3 rst_sys_n = 1'b0;
        #1;
        check("r1_halted", 64'(halted), 64'd0);
        check("r1_drop", 64'(drop_cnt), 64'd0);
        model_reset();
        @(posedge clk);
        #1 rst_sys_n = 1'b1;
        idle(1);

        // four records queued and halted, then reset mid-cycle
        ev_ready = 1'b0;
        for (int i = 0; i < 3; i++) retire(I_PUTC, 32'h5000 + 32'(4*i), 32'h500 + 32'(i), 1'b0, 1'b1, EV_PUTC, 4'd0, 1'b0);
        retire(I_EXIT, 32'h500C, 32'h0, 1'b0, 1'b1, EV_EXIT, 4'd0, 1'b0);
        halted_m = 1'b1;
        check("t5_halted", 64'(halted), 64'd1);
        check("t5_valid", 64'(ev_valid), 64'd1);
        check("t5_head", 64'(ev_r3), 64'h500);
        @(posedge clk);
        #3 rst_sys_n = 1'b0;
        #1;
        check("t5_rst_valid", 64'(ev_valid), 64'd0);
        check("t5_rst_halted", 64'(halted), 64'd0);
        check("t5_rst_drop", 64'(drop_cnt), 64'd0);
        check("t5_rst_r3", 64'(ev_r3), 64'd0);
        model_reset();
        @(posedge clk);
        #1 rst_sys_n = 1'b1;
        ev_ready = 1'b1;
        retire(I_PUTC, 32'h6000, 32'h66, 1'b0, 1'b1, EV_PUTC, 4'd0, 1'b0);
        check("t5_time0", 64'(ev_time), 64'd0);
        wait_drain("t5_drain", 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/trace_event_capture.md
# trace_event_capture

Synthesizable capture stage sitting between the OR1200 write-back stage of a compute tile core and the trace/stdout consumer. It watches every retired instruction, recognises the simulation-control `l.nop K` forms (exit, putc, user event), and stamps each one with a retired-instruction count. Each event is queued in a small FIFO and offered downstream on a valid/ready interface. The consumer (trace monitor, debug NoC packetizer) therefore no longer needs hierarchical probes into the CPU.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries. Power of two, ≥2.
- `CNT_WIDTH`, 32: width of the retired-instruction counter. Wraps modulo 2^CNT_WIDTH.

Ports:
- `clk`  in  1  tile clock.
- `rst_sys_n`  in  1  **one clock; reset is asynchronous and active-low**.
- `enable`  in  1  one instruction retires this cycle (the inverse of the core's wb_freeze).
- `wb_pc`  in  32  PC of the retiring instruction.
- `wb_insn`  in  32  retiring instruction word.
- `r3`  in  32  current value of GPR r3.
- `supv`  in  1  supervisor mode flag.
- `ev_valid`  out  1  head record available.
- `ev_ready`  in  1  consumer accepts the head record.
- `ev_type`  out  2  event type: 0 = exit, 1 = putc, 2 = user.
- `ev_code`  out  4  K[3:0] for user events, otherwise 0.
- `ev_pc`, `ev_r3`  out  32 each  captured PC and r3.
- `ev_supv`  out  1  captured supervisor flag.
- `ev_time`  out  CNT_WIDTH  retire count at capture.
- `ev_lost`  out  1  one or more events were dropped immediately before this record.
- `halted`  out  1  an exit event has been captured.
- `drop_cnt`  out  8  saturating count of dropped events.

## Operation
- Decode runs only when `enable`=1. An instruction is an event when `wb_insn[31:24]==8'h15` and K=`wb_insn[15:0]` takes one of these values:
  - 0x0001 → exit;
  - 0x0004 → putc;
  - 0x0020–0x002F → user, with code K[3:0].
- Any other K, or any other opcode, is not an event.
- Retire counter: increments on every `enable` cycle while in RUN. The value stored with an event is the count *before* the increment, so the first retired instruction after reset has time 0.
- States:
  - RUN (reset state): events are captured.
  - HALTED: entered in the cycle after an exit event is pushed. In HALTED, no capture occurs, the counter freezes and `halted`=1. The FIFO continues to drain.
  - HALTED is left only by reset.
- A dropped exit event does not cause HALTED; the exit is lost.
- Push: a decoded event is pushed when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
- Otherwise the event is dropped:
  - `drop_cnt` increments, saturating at 255;
  - a sticky lost flag is set.
- The next pushed record carries `ev_lost`=1, and the sticky flag clears on that push.
- Pop: occurs when `ev_valid` and `ev_ready` are both 1. Output fields are stable while `ev_valid`=1 and `ev_ready`=0.
- Reset mid-operation:
  - all FIFO contents are discarded;
  - the counter, `drop_cnt` and the lost flag clear;
  - the state returns to RUN.

## Timing
- Reset values:
  - `ev_valid`=0, `halted`=0, `drop_cnt`=0;
  - all `ev_*` data outputs are 0.
- Latency: an event retired in cycle N produces `ev_valid`=1 in cycle N+1 when the FIFO was empty. There is no combinational path from the inputs to the outputs.
- `ev_*` outputs are driven from registered FIFO head storage.
- `ev_ready` has no combinational path to any output other than through the next-cycle state.
- Full throughput: one push and one pop per cycle sustained.
- Empty FIFO with a simultaneous decode and `ev_ready`=1: the new record is not popped in the same cycle. There is no fall-through.
- `halted` rises in cycle N+1 after an exit pushed in cycle N.

## Structure
- Package `trace_event_pkg` holds:
  - `ev_type_t` enum (EV_EXIT, EV_PUTC, EV_USER);
  - the packed `trace_event_t` struct (type, code, pc, r3, supv, time, lost);
  - constants NOP_OPCODE=8'h15, K_EXIT=16'h0001, K_PUTC=16'h0004, K_USER_BASE=16'h0020.
- Sub-module `trace_event_fifo`: a parameterised synchronous FIFO of `trace_event_t`, with `DEPTH` entries, full/empty flags and pointer wrap on log2(DEPTH) bits plus a phase bit.
- Top level contains the decode logic, the retire counter, the RUN/HALTED FSM and the drop/lost logic.

## Test plan
- Retire `l.nop 0x4` with r3=0x41, PC 0x2000, after 5 plain retirements. Required: one record with type=1, r3=0x41, pc=0x2000, time=5, lost=0, `ev_valid` one cycle later.
- Retire `l.nop 0x25` in supervisor mode, then `l.nop 0x40`, then `l.add`. Required: exactly one record, type=2, code=5, supv=1.
- Hold `ev_ready`=0 and push 8 putc events (DEPTH=8), then 3 more, then one exit. Required:
  - `drop_cnt`=3;
  - after draining, the records appear in order and the 9th record (the exit) has lost=1;
  - `halted`=1;
  - later `l.nop 0x4` retirements produce nothing.
- With the FIFO full and `ev_ready`=1, retire one event per cycle for 20 cycles. Required: `drop_cnt` stays 0, all 20 records are delivered in order and time increments by 1 per record.
- Assert `rst_sys_n`=0 asynchronously mid-cycle with 4 records queued and `halted`=1. Required: `ev_valid`, `halted` and `drop_cnt` go to 0 immediately; after release, the next event has time 0.
